modulo_7seg_multiplex: RTL and testbench

MODULO_7SEG_MULTIPLEX -- requirements
Module: modulo_7seg_multiplex

---
 rtl/modulo_7seg_multiplex.sv | 147 ++++++++++++++
 tb/tb_modulo_7seg_multiplex.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/modulo_7seg_multiplex.sv
// Multiplexed hex seven-segment display driver.
// Captures NUM_DIGITS hex nibbles plus decimal-point requests into shadow
// registers. It scans one digit per REFRESH_DIV clock cycles and drives
// active-low segments, decimal point and anodes from registered outputs.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero
// digits. Digit 0 is never blanked.
module modulo_7seg_multiplex #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    enable,
   output logic [6:0]              display,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   anode
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [CNT_W-1:0]        refresh_count;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] data_shadow;
   logic [NUM_DIGITS-1:0]   dp_shadow;

   logic                    last_count;
   logic [3:0]              cur_nibble;
   logic                    cur_dp;
   logic [NUM_DIGITS-1:0]   cur_sel;
   logic [6:0]              seg_next;

   // Active-low hex font, segment order {a,b,c,d,e,f,g}; anything unknown goes dark
   function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
      case (nibble)
         4'h0:    seg_decode = 7'b0000001;
         4'h1:    seg_decode = 7'b1001111;
         4'h2:    seg_decode = 7'b0010010;
         4'h3:    seg_decode = 7'b0000110;
         4'h4:    seg_decode = 7'b1001100;
         4'h5:    seg_decode = 7'b0100100;
         4'h6:    seg_decode = 7'b0100000;
         4'h7:    seg_decode = 7'b0001111;
         4'h8:    seg_decode = 7'b0000000;
         4'h9:    seg_decode = 7'b0000100;
         4'hA:    seg_decode = 7'b0001000;
         4'hB:    seg_decode = 7'b1100000;
         4'hC:    seg_decode = 7'b0110001;
         4'hD:    seg_decode = 7'b1000010;
         4'hE:    seg_decode = 7'b0110000;
         4'hF:    seg_decode = 7'b0111000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   assign last_count = (refresh_count == CNT_W'(REFRESH_DIV - 1));

   // Free-running refresh counter; it ignores enable and load so the scan rate stays fixed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh_count <= '0;
      end else if (last_count) begin
         refresh_count <= '0;
      end else begin
         refresh_count <= refresh_count + 1'b1;
      end
   end

   // Digit index steps once per refresh period and wraps after the last digit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (last_count) begin
         if (idx == IDX_W'(NUM_DIGITS - 1)) begin
            idx <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Shadow registers hold the displayed value between load strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_shadow <= '0;
         dp_shadow   <= '0;
      end else if (load) begin
         data_shadow <= data;
         dp_shadow   <= dp_in;
      end
   end

   // Select the nibble, decimal point and one-hot anode for the current index
   always_comb begin
      cur_nibble = 4'h0;
      cur_dp     = 1'b0;
      cur_sel    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nibble = data_shadow[4*i +: 4];
            cur_dp     = dp_shadow[i];
            cur_sel[i] = 1'b1;
         end
      end
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic blank;

   // A digit above 0 is blanked when it and every more significant nibble are zero
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      blank      = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero = upper_zero && (data_shadow[4*i +: 4] == 4'h0);
         if ((idx == IDX_W'(i)) && upper_zero) begin
            blank = 1'b1;
         end
      end
      seg_next = blank ? 7'b1111111 : seg_decode(cur_nibble);
   end
`else
   assign seg_next = seg_decode(cur_nibble);
`endif

   // Registered outputs: they show last cycle's index and shadow contents, or go dark when disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         display <= 7'b1111111;
         dp      <= 1'b1;
         anode   <= '1;
      end else if (enable) begin
         display <= seg_next;
         dp      <= ~cur_dp;
         anode   <= ~cur_sel;
      end else begin
         display <= 7'b1111111;
         dp      <= 1'b1;
         anode   <= '1;
      end
   end

endmodule

// File: tb/tb_modulo_7seg_multiplex.sv
// Self-checking bench for modulo_7seg_multiplex with NUM_DIGITS=4 and REFRESH_DIV=4.
// An arithmetic model predicts every output cycle. Directed literal checks pin
// the model to hand-computed values.
module tb_modulo_7seg_multiplex;

   localparam int ND = 4;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] data = '0;
   logic [3:0]  dp_in = '0;
   logic [6:0]  display;
   logic        dp;
   logic [3:0]  anode;

   int tests = 0;
   int fails = 0;
   bit compare_en = 1'b0;

   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   int          edges;
   logic [15:0] sh_data;
   logic [3:0]  sh_dp;
   logic [3:0]  exp_anode;
   logic [6:0]  exp_display;
   logic        exp_dp;

   modulo_7seg_multiplex #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
      .enable(enable), .display(display), .dp(dp), .anode(anode)
   );

   // 100 MHz style clock
   always #5 clk = ~clk;

   // Model: the digit shown follows from the number of edges since reset, not from any counter state
   always @(posedge clk or posedge rst) begin : model
      logic [1:0]  m_idx;
      logic [15:0] m_upper;
      logic        m_blank;
      if (rst) begin
         edges       <= 0;
         sh_data     <= '0;
         sh_dp       <= '0;
         exp_anode   <= 4'b1111;
         exp_display <= 7'b1111111;
         exp_dp      <= 1'b1;
      end else begin
         m_idx   = 2'((edges / RD) % ND);
         m_upper = sh_data >> (4 * m_idx);
         m_blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
         m_blank = (m_idx != 2'd0) && (m_upper == 16'h0);
`endif
         if (enable) begin
            exp_anode   <= ~(4'b0001 << m_idx);
            exp_display <= m_blank ? 7'b1111111 : seg_tab[m_upper[3:0]];
            exp_dp      <= ~sh_dp[m_idx];
         end else begin
            exp_anode   <= 4'b1111;
            exp_display <= 7'b1111111;
            exp_dp      <= 1'b1;
         end
         if (load) begin
            sh_data <= data;
            sh_dp   <= dp_in;
         end
         edges <= edges + 1;
      end
   end

   // Every-cycle comparison against the model on the falling edge
   always @(negedge clk) begin
      if (compare_en) begin
         tests++;
         if ({anode, display, dp} !== {exp_anode, exp_display, exp_dp}) begin
            fails++;
            $display("[TB] FAIL cycle_compare t=%0t got anode=%b display=%b dp=%b want anode=%b display=%b dp=%b",
                     $time, anode, display, dp, exp_anode, exp_display, exp_dp);
         end
      end
   end

   task automatic stepTo(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic l, input logic [15:0] d, input logic [3:0] p, input logic en);
      load   = l;
      data   = d;
      dp_in  = p;
      enable = en;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] ea, input logic [6:0] ed, input logic edp);
      tests++;
      if ({anode, display, dp} !== {ea, ed, edp}) begin
         fails++;
         $display("[TB] FAIL %s got anode=%b display=%b dp=%b want anode=%b display=%b dp=%b",
                  name, anode, display, dp, ea, ed, edp);
      end
   endtask

   task automatic waitAnode(input logic [3:0] pattern);
      int n;
      n = 0;
      while (anode !== pattern && n < 40) begin
         stepTo(1);
         n++;
      end
      if (anode !== pattern) begin
         tests++;
         fails++;
         $display("[TB] FAIL wait_anode got anode=%b want anode=%b within 40 cycles", anode, pattern);
      end
   endtask

   // Directed sequence
   initial begin
      applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b1);
      stepTo(2);
      compare_en = 1'b1;
      checkOutput("reset_state", 4'b1111, 7'b1111111, 1'b1);

      // Scan order after release
      rst = 1'b0;
      stepTo(1);
      checkOutput("first_edge_digit0", 4'b1110, 7'b0000001, 1'b1);
      stepTo(3);
      checkOutput("digit0_held", 4'b1110, 7'b0000001, 1'b1);
      stepTo(1);
      checkOutput("scan_digit1", 4'b1101, 7'b0000001, 1'b1);
      stepTo(4);
      checkOutput("scan_digit2", 4'b1011, 7'b0000001, 1'b1);
      stepTo(4);
      checkOutput("scan_digit3", 4'b0111, 7'b0000001, 1'b1);
      stepTo(4);
      checkOutput("scan_wrap", 4'b1110, 7'b0000001, 1'b1);

      // Decode and decimal point
      applyStimulus(1'b1, 16'hA5F0, 4'b0100, 1'b1);
      stepTo(1);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b1);
      stepTo(1);
      waitAnode(4'b1110);
      checkOutput("decode_digit0", 4'b1110, 7'b0000001, 1'b1);
      waitAnode(4'b1101);
      checkOutput("decode_digit1", 4'b1101, 7'b0111000, 1'b1);
      waitAnode(4'b1011);
      checkOutput("decode_digit2_dp", 4'b1011, 7'b0100100, 1'b0);
      waitAnode(4'b0111);
      checkOutput("decode_digit3", 4'b0111, 7'b0001000, 1'b1);

      // Enable drop mid-scan resumes at the current index
      waitAnode(4'b1011);
      enable = 1'b0;
      stepTo(1);
      checkOutput("enable_dark", 4'b1111, 7'b1111111, 1'b1);
      enable = 1'b1;
      stepTo(1);
      checkOutput("enable_resume", 4'b1011, 7'b0100100, 1'b0);

      // Load coinciding with an index advance
      waitAnode(4'b0111);
      stepTo(2);
      applyStimulus(1'b1, 16'h1111, 4'b0000, 1'b1);
      stepTo(1);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b1);
      checkOutput("collision_old_digit", 4'b0111, 7'b0001000, 1'b1);
      stepTo(1);
      checkOutput("collision_new_digit", 4'b1110, 7'b1001111, 1'b1);

      // Reset in the middle of a scan
      stepTo(5);
      rst = 1'b1;
      #1;
      checkOutput("async_reset", 4'b1111, 7'b1111111, 1'b1);
      stepTo(1);
      rst = 1'b0;
      stepTo(1);
      checkOutput("post_reset_cleared", 4'b1110, 7'b0000001, 1'b1);

      // Leading zero handling
      applyStimulus(1'b1, 16'h0030, 4'b0000, 1'b1);
      stepTo(1);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b1);
      stepTo(1);
      waitAnode(4'b1101);
      checkOutput("lz_digit1", 4'b1101, 7'b0000110, 1'b1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      waitAnode(4'b1011);
      checkOutput("lz_digit2", 4'b1011, 7'b1111111, 1'b1);
      waitAnode(4'b0111);
      checkOutput("lz_digit3", 4'b0111, 7'b1111111, 1'b1);
`else
      waitAnode(4'b1011);
      checkOutput("lz_digit2", 4'b1011, 7'b0000001, 1'b1);
      waitAnode(4'b0111);
      checkOutput("lz_digit3", 4'b0111, 7'b0000001, 1'b1);
`endif
      waitAnode(4'b1110);
      checkOutput("lz_digit0", 4'b1110, 7'b0000001, 1'b1);

      stepTo(3);
      compare_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
